// File: rtl/digit_glyph_renderer.sv
// -----------------------------------------------------------------------------
// digit_glyph_renderer
//
// Overlays NUM_DIGITS decimal digits, each a 24x24 glyph, onto a VGA pixel
// stream at (ORIGIN_X, ORIGIN_Y). The block drives the row addresses for an
// external glyph ROM (256 x 24-bit, 1-cycle registered read). It then turns
// each returned 24-bit row into per-pixel fg/bg colour. The output is
// time-aligned to the input stream with a fixed 3-cycle latency.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   pix_x/pix_y  current pixel coordinates (10 bits each)
//   pix_valid    active-video pixel; pix_x advances by 1 per valid cycle
//   frame_start  1-cycle pulse ahead of a frame; latches `value`
//   value        BCD digits, digit 0 (most significant) in the top nibble
//   rom_addr     glyph ROM row address (registered)
//   rom_rdata    glyph ROM row data, valid 1 cycle after rom_addr
//   rgb          output colour (0 when rgb_valid is low)
//   rgb_valid    pix_valid delayed by 3 cycles
//   glyph_on     rgb is a lit glyph pixel
// -----------------------------------------------------------------------------
module digit_glyph_renderer #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [9:0]  ORIGIN_X   = 10'd100,
    parameter logic [9:0]  ORIGIN_Y   = 10'd100,
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000,
    parameter bit          LZ_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              pix_x,
    input  logic [9:0]              pix_y,
    input  logic                    pix_valid,
    input  logic                    frame_start,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [7:0]              rom_addr,
    input  logic [23:0]             rom_rdata,
    output logic [23:0]             rgb,
    output logic                    rgb_valid,
    output logic                    glyph_on
);

    localparam int             VW       = 4 * NUM_DIGITS;
    localparam int             DW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0]  LAST_DIG = DW'(NUM_DIGITS - 1);
    localparam logic [4:0]     LAST_COL = 5'd23;
    localparam logic [10:0]    ROW_END  = {1'b0, ORIGIN_Y} + 11'd23;

    // Frame-latched state. armed_q stays low after reset until the next
    // frame_start, so a mid-frame reset never draws from a cleared value.
    logic [VW-1:0] value_q;
    logic          armed_q;

    // Column/digit position the next valid pixel will take while active.
    logic          active_q;
    logic [4:0]    col_q;
    logic [DW-1:0] dig_q;

    // Pipeline stages c1 and c2.
    logic [4:0] col_d1, col_d2;
    logic       box_d1, box_d2;
    logic       blank_d1, blank_d2;
    logic       valid_d1, valid_d2;

    // Stage c0: position and blanking of the current input pixel.
    logic [VW-1:0]         value_cur;
    logic                  armed_cur;
    logic                  in_row;
    logic                  start;
    logic                  cur_active;
    logic [4:0]            cur_col;
    logic [DW-1:0]         cur_dig;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  in_box;
    logic [9:0]            row_off;
    logic [7:0]            addr_next;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [3:0]            scan_nib;
    logic                  zeros_above;
    logic                  lit;

    // A frame_start that coincides with a valid pixel already applies to that pixel.
    assign value_cur = frame_start ? value : value_q;
    assign armed_cur = frame_start | armed_q;

    assign in_row     = ({1'b0, pix_y} >= {1'b0, ORIGIN_Y}) && ({1'b0, pix_y} <= ROW_END);
    assign start      = pix_valid && in_row && (pix_x == ORIGIN_X);
    assign cur_active = start || active_q;
    assign cur_col    = start ? 5'd0 : col_q;
    assign cur_dig    = start ? '0 : dig_q;
    assign in_box     = pix_valid && cur_active && in_row && armed_cur;

    assign row_off   = pix_y - ORIGIN_Y;
    assign cur_nib   = value_cur[VW-1-4*int'(cur_dig) -: 4];
    assign cur_blank = blank_vec[cur_dig];
    assign addr_next = 8'(cur_nib) * 8'd24 + {3'b000, row_off[4:0]};

    // Scan from the most significant digit. zeros_above stays set while every
    // digit seen so far is zero, which marks the leading zeros.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        blank_vec   = '0;
        scan_nib    = 4'd0;
        zeros_above = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            scan_nib     = value_cur[VW-1-4*i -: 4];
            blank_vec[i] = (scan_nib > 4'd9) ||
                           (LZ_BLANK && zeros_above && (scan_nib == 4'd0) && (i != NUM_DIGITS - 1));
            zeros_above  = zeros_above && (scan_nib == 4'd0);
        end
    end

    // Frame latch and column/digit counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= '0;
            armed_q  <= 1'b0;
            active_q <= 1'b0;
            col_q    <= 5'd0;
            dig_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (frame_start) begin
                value_q <= value;
                armed_q <= 1'b1;
            end
            // Counters move only on valid pixels; blank cycles hold them.
            if (pix_valid && cur_active) begin
                active_q <= 1'b1;
                if (cur_col == LAST_COL) begin
                    col_q <= 5'd0;
                    if (cur_dig == LAST_DIG) begin
                        active_q <= 1'b0;
                    end else begin
                        dig_q <= cur_dig + 1'b1;
                    end
                end else begin
                    col_q <= cur_col + 5'd1;
                    dig_q <= cur_dig;
                end
            end
        end
    end

    // Stage c1 (ROM address issue) and stage c2 (wait for ROM data).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= 8'd0;
            col_d1   <= 5'd0;
            box_d1   <= 1'b0;
            blank_d1 <= 1'b0;
            valid_d1 <= 1'b0;
            col_d2   <= 5'd0;
            box_d2   <= 1'b0;
            blank_d2 <= 1'b0;
            valid_d2 <= 1'b0;
        end else begin
            // Blanked digits and pixels outside the box park the address at 0.
            rom_addr <= (in_box && !cur_blank) ? addr_next : 8'd0;
            col_d1   <= cur_col;
            box_d1   <= in_box;
            blank_d1 <= cur_blank;
            valid_d1 <= pix_valid;
            col_d2   <= col_d1;
            box_d2   <= box_d1;
            blank_d2 <= blank_d1;
            valid_d2 <= valid_d1;
        end
    end

    // Column 0 is the MSB of the row word.
    assign lit = rom_rdata[LAST_COL - col_d2] & box_d2 & ~blank_d2;

    // Stage c3: colour output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= 24'd0;
            rgb_valid <= 1'b0;
            glyph_on  <= 1'b0;
        end else begin
            rgb       <= valid_d2 ? (lit ? FG_COLOR : BG_COLOR) : 24'd0;
            rgb_valid <= valid_d2;
            glyph_on  <= lit;
        end
    end

endmodule

// File: tb/tb_digit_glyph_renderer.sv
// -----------------------------------------------------------------------------
// tb_digit_glyph_renderer
//
// Self-checking bench for digit_glyph_renderer. It uses a registered-read ROM
// model. Each driven pixel pushes its expected output (from an x/y-based
// reference model) onto a scoreboard queue, and the entry is popped and
// compared 3 cycles later. Each scenario task also checks rom_addr and the
// reset behaviour inline.
// -----------------------------------------------------------------------------
module tb_digit_glyph_renderer;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        pix_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] value = '0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_rdata = '0;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic        glyph_on;

    logic [23:0] rom_mem [256];

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        logic        v;
        logic        g;
    } exp_t;

    exp_t exp_q[$];

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    logic [15:0] tb_latched = '0;
    bit          tb_armed = 1'b0;

    always #5 clk = ~clk;

    // Glyph ROM model: 1-cycle registered read.
    always @(posedge clk) rom_rdata <= rom_mem[rom_addr];

    digit_glyph_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .value      (value),
        .rom_addr   (rom_addr),
        .rom_rdata  (rom_rdata),
        .rgb        (rgb),
        .rgb_valid  (rgb_valid),
        .glyph_on   (glyph_on)
    );

    // Reference: the glyph box spans x 100..195, y 100..123; digit = (x-100)/24.
    function automatic logic model_lit(input int x, input int y);
        int          d;
        int          c;
        logic [3:0]  nib;
        logic [15:0] above;
        logic [7:0]  a;
        if (!tb_armed || y < 100 || y > 123 || x < 100 || x > 195) return 1'b0;
        d     = (x - 100) / 24;
        c     = (x - 100) % 24;
        nib   = tb_latched[4*(3-d) +: 4];
        above = tb_latched >> (4 * (3 - d));
        if (nib > 4'd9) return 1'b0;
        if (d != 3 && above == 16'h0) return 1'b0;
        a = 8'(int'(nib) * 24 + (y - 100));
        return rom_mem[a][23-c];
    endfunction

    // Drive one pixel cycle, push its expectation and retire any due outputs.
    task automatic tick(input int x, input int y, input logic v, input logic fs);
        exp_t e;
        pix_x       = 10'(x);
        pix_y       = 10'(y);
        pix_valid   = v;
        frame_start = fs;
        if (fs) begin
            tb_latched = value;
            tb_armed   = 1'b1;
        end
        if (rst_n) begin
            e.cyc = cyc;
            e.v   = v;
            e.g   = v && model_lit(x, y);
            e.rgb = v ? (e.g ? FG : BG) : 24'h0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        while (exp_q.size() > 0 && exp_q[0].cyc + 3 <= cyc) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rgb_valid !== e.v || rgb !== e.rgb || glyph_on !== e.g) begin
                tests_failed++;
                $display("FAIL pixel@cyc%0d: got v=%b rgb=%h g=%b, want v=%b rgb=%h g=%b",
                         e.cyc, rgb_valid, rgb, glyph_on, e.v, e.rgb, e.g);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic sweep_row(input int y);
        for (int x = 96; x <= 200; x++) tick(x, y, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(200, y, 1'b0, 1'b0);
    endtask

    task automatic new_frame(input logic [15:0] v);
        value = v;
        tick(0, 0, 1'b0, 1'b1);
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < 256; i++) rom_mem[i] = 24'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick(0, 0, 1'b0, 1'b0);
        tests_run++;
        if ({rom_addr, rgb, rgb_valid, glyph_on} !== 34'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got addr=%h rgb=%h v=%b g=%b, want all 0",
                     rom_addr, rgb, rgb_valid, glyph_on);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_addr_1234();
        fill_rom_random();
        new_frame(16'h1234);
        sweep_row(99);
        for (int x = 96; x <= 200; x++) begin
            tick(x, 100, 1'b1, 1'b0);
            if (x == 100 || x == 124 || x == 148 || x == 172) begin
                tests_run++;
                if (rom_addr !== 8'(((x - 100) / 24 + 1) * 24)) begin
                    tests_failed++;
                    $display("FAIL addr_1234 x=%0d: got %0d want %0d",
                             x, rom_addr, ((x - 100) / 24 + 1) * 24);
                end
            end
        end
        for (int i = 0; i < 4; i++) tick(200, 100, 1'b0, 1'b0);
        for (int y = 101; y <= 124; y++) sweep_row(y);
    endtask

    task automatic test_bit_order();
        for (int i = 0; i < 256; i++) rom_mem[i] = 24'h800001;
        new_frame(16'h1234);
        for (int y = 100; y <= 103; y++) sweep_row(y);
        // Idle gaps mid-row must hold the counters.
        for (int x = 96; x <= 200; x++) begin
            if (x % 5 == 0) tick(x, 104, 1'b0, 1'b0);
            tick(x, 104, 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) tick(200, 104, 1'b0, 1'b0);
    endtask

    task automatic test_lz_blank();
        logic [7:0] want;
        fill_rom_random();
        new_frame(16'h0050);
        for (int x = 96; x <= 200; x++) begin
            tick(x, 105, 1'b1, 1'b0);
            if (x == 100 || x == 124 || x == 148 || x == 172) begin
                want = (x == 148) ? 8'd125 : (x == 172) ? 8'd5 : 8'd0;
                tests_run++;
                if (rom_addr !== want) begin
                    tests_failed++;
                    $display("FAIL lz_0050 x=%0d: got %0d want %0d", x, rom_addr, want);
                end
            end
        end
        sweep_row(100);
        sweep_row(123);
        new_frame(16'h0000);
        for (int x = 96; x <= 200; x++) begin
            tick(x, 105, 1'b1, 1'b0);
            if (x == 100 || x == 124 || x == 148 || x == 172) begin
                want = (x == 172) ? 8'd5 : 8'd0;
                tests_run++;
                if (rom_addr !== want) begin
                    tests_failed++;
                    $display("FAIL lz_0000 x=%0d: got %0d want %0d", x, rom_addr, want);
                end
            end
        end
        sweep_row(110);
    endtask

    task automatic test_bad_bcd();
        logic [7:0] want;
        fill_rom_random();
        new_frame(16'h1A34);
        for (int x = 96; x <= 200; x++) begin
            tick(x, 107, 1'b1, 1'b0);
            if (x >= 100 && x <= 148) begin
                want = (x == 100) ? 8'd31 : (x == 148) ? 8'd79 : (x >= 124) ? 8'd0 : 8'(24 + 7);
                tests_run++;
                if (rom_addr !== want) begin
                    tests_failed++;
                    $display("FAIL bad_bcd x=%0d: got %0d want %0d", x, rom_addr, want);
                end
            end
        end
        sweep_row(120);
    endtask

    task automatic test_frame_latch();
        fill_rom_random();
        new_frame(16'h1111);
        for (int y = 100; y <= 109; y++) sweep_row(y);
        value = 16'h2222;
        for (int y = 110; y <= 123; y++) sweep_row(y);
        // Next frame_start arrives together with the first glyph pixel.
        for (int x = 96; x <= 200; x++) begin
            tick(x, 100, 1'b1, x == 100);
            if (x == 100) begin
                tests_run++;
                if (rom_addr !== 8'd48) begin
                    tests_failed++;
                    $display("FAIL latch_same_cycle: got %0d want 48", rom_addr);
                end
            end
        end
        for (int i = 0; i < 4; i++) tick(200, 100, 1'b0, 1'b0);
        for (int y = 101; y <= 103; y++) sweep_row(y);
    endtask

    task automatic test_mid_frame_reset();
        fill_rom_random();
        new_frame(16'h1234);
        for (int y = 100; y <= 104; y++) sweep_row(y);
        for (int x = 96; x <= 110; x++) tick(x, 105, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rom_addr, rgb, rgb_valid, glyph_on} !== 34'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: got addr=%h rgb=%h v=%b g=%b, want all 0",
                     rom_addr, rgb, rgb_valid, glyph_on);
        end
        exp_q.delete();
        tb_armed   = 1'b0;
        tb_latched = '0;
        tick(110, 105, 1'b0, 1'b0);
        tick(110, 105, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int x = 111; x <= 200; x++) tick(x, 105, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(200, 105, 1'b0, 1'b0);
        for (int y = 106; y <= 123; y++) sweep_row(y);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 24'h0;
        test_reset();
        test_addr_1234();
        test_bit_order();
        test_lz_blank();
        test_bad_bcd();
        test_frame_latch();
        test_mid_frame_reset();
        for (int i = 0; i < 6; i++) tick(0, 0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
